ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 6500, clk cycles ps2_clk is held low before request-to-send (100 us at 65 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1300000, max clk cycles without a device ps2_clk falling edge before abort (20 ms at 65 MHz).
REQ-003 clk  input  1  system clock; the block has one clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 tx_start  input  1  one-cycle request to send tx_data; ignored while tx_busy=1.
REQ-006 tx_data  input  8  command byte, captured on the accepted tx_start cycle.
REQ-007 ps2_clk_in  input  1  raw PS/2 clock line level, asynchronous.
REQ-008 ps2_data_in  input  1  raw PS/2 data line level, asynchronous.
REQ-009 ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release (open-collector, pull-up external).
REQ-010 ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-011 tx_busy  output  1  high from the cycle after tx_start acceptance until DONE/ERR exits.
REQ-012 tx_done  output  1  one-cycle pulse: frame sent and device ACK (data low) sampled.
REQ-013 tx_err  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-014 ps2_clk_in/ps2_data_in SHALL pass a 2-flop synchronizer; a falling edge (fe) is sync'd clk 1->0 between consecutive cycles; fe is ignored while ps2_clk_oe=1.
REQ-015 States: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_REL, DONE, ERR.
REQ-016 IDLE: both oe=0; tx_start=1 -> latch tx_data, compute odd parity (~^tx_data), load 11-bit shift reg {1(stop),parity,data[7:0]}, bit counter=0 -> INHIBIT.
REQ-017 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles -> RTS.
REQ-018 RTS: ps2_data_oe=1 (start bit 0) and ps2_clk_oe=1 for 1 cycle, then ps2_clk_oe=0 -> SEND.
REQ-019 SEND: on each fe, ps2_data_oe = ~shift[0], shift right, counter+1; LSB first: data0..data7, parity, stop (oe=0); after 10th fe (stop placed) -> ACK.
REQ-020 ACK: on next fe, sample sync'd data: 0 -> WAIT_REL, 1 -> ERR.
REQ-021 WAIT_REL: wait until sync'd clk=1 and data=1 on the same cycle -> DONE.
REQ-022 DONE: tx_done=1 for one cycle -> IDLE; ERR: tx_err=1 for one cycle, both oe=0 -> IDLE.
REQ-023 Timeout counter SHALL clear on every fe and on entry to SEND; in SEND, ACK or WAIT_REL reaching TIMEOUT_CYCLES -> ERR.
REQ-024 tx_start during tx_busy=1 SHALL be dropped without effect; tx_start in the DONE/ERR cycle is dropped.
REQ-025 tx_done and tx_err SHALL never assert in the same cycle; each frame ends in exactly one of them.
REQ-026 Counters sized from $clog2 of their parameter; bit counter 4 bits, saturates at 11.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, counters 0, synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL release both lines immediately; no tx_done/tx_err pulse follows reset release.

Structure
REQ-029 Shared package kb_pkg SHALL hold state enum and command constants CMD_RESET=8'hFF, CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, ACK_BYTE=8'hFA.
REQ-030 Sub-module ps2_line_sync SHALL implement the 2-flop synchronizers and fe detect, reusable by the scan-code receiver.
REQ-031 Tri-state buffers SHALL live in the top level, not in this block.

Verification
REQ-032 tx_data=8'hED, device model clock 12.5 kHz, ACK low -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1, tx_done once, tx_busy low after.
REQ-033 tx_data=8'h00 -> parity bit 1; tx_data=8'h01 -> parity bit 0.
REQ-034 INHIBIT_CYCLES=100 -> ps2_clk_oe high exactly 101 cycles (100 + RTS), data_oe rises on cycle 101.
REQ-035 Device omits ACK (data high at 11th fe) -> tx_err one pulse, tx_done never, both oe=0.
REQ-036 TIMEOUT_CYCLES=500, device stops clocking after 4th bit -> tx_err 500 cycles after last fe, lines released.
REQ-037 reset_n low during SEND bit 5 -> oe both 0 same cycle, IDLE after release; second tx_start while busy ignored.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 keyboard interface blocks.
//
// Contents:
//   tx_state_e    - state encoding of the host-to-device transmitter
//   CMD_*         - common host-to-keyboard command bytes
//   ACK_BYTE      - byte the keyboard returns after accepting a command
//   SHIFT_W       - width of the transmit shift register
//   odd_parity()  - PS/2 parity bit for a data byte
package kb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_SEND     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } tx_state_e;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Shift register: data[7:0], parity, stop, plus one spare '1' on top.
    localparam int SHIFT_W = 11;

    // Bit-counter value seen on the falling edge that places the stop bit.
    localparam logic [3:0] LAST_BIT_CNT = 4'd9;
    localparam logic [3:0] BIT_CNT_MAX  = 4'd11;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock. Shared by the host
// transmitter and the scan-code receiver.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset (flops reset to idle-high)
//   i_ps2_clk    raw PS/2 clock line level (asynchronous)
//   i_ps2_data   raw PS/2 data line level (asynchronous)
//   o_clk_sync   synchronized clock level
//   o_data_sync  synchronized data level, aligned with o_clk_sync
//   o_clk_fe     one-cycle pulse: synchronized clock went 1 -> 0
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_clk_fe
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_data_meta;
    logic r_data_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= i_ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= i_ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    assign o_clk_sync  = r_clk_sync;
    assign o_data_sync = r_data_sync;
    assign o_clk_fe    = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues a
// request-to-send, shifts out one byte on device-generated clock edges and
// checks the device acknowledge. Line drivers are open-collector enables;
// the actual tri-state buffers sit in the chip top level.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before RTS
//   TIMEOUT_CYCLES  max clk cycles between device clock falling edges
//
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   tx_start        one-cycle send request, accepted only when idle
//   tx_data         command byte, captured with the accepted tx_start
//   ps2_clk_in      raw PS/2 clock line level
//   ps2_data_in     raw PS/2 data line level
//   ps2_clk_oe      1 = pull PS/2 clock low
//   ps2_data_oe     1 = pull PS/2 data low
//   tx_busy         frame in progress
//   tx_done         one-cycle pulse: frame sent and acknowledged
//   tx_err          one-cycle pulse: timeout or missing acknowledge
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | lines released, waiting for tx_start
// INHIBIT  | clock held low for INHIBIT_CYCLES
// RTS      | clock and data both low for one cycle (start bit placed)
// SEND     | on each device clock fall place next bit; 10 falls total
// ACK      | on next fall sample data: low = acknowledged
// WAIT_REL | wait for device to release clock and data
// DONE     | tx_done pulse
// ERR      | tx_err pulse, lines released
module ps2_host_tx
    import kb_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 1300000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

    tx_state_e            r_state;
    tx_state_e            w_next;
    logic [SHIFT_W-1:0]   r_shift;
    logic [3:0]           r_bit_cnt;
    logic [INH_W-1:0]     r_inh_cnt;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_data_drv;

    logic w_clk_sync;
    logic w_data_sync;
    logic w_clk_fe_raw;
    logic w_fe;
    logic w_clk_drive;
    logic w_data_oe;
    logic w_done;
    logic w_err;
    logic w_timing;
    logic w_to_expired;

    ps2_line_sync u_line_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_ps2_clk   (ps2_clk_in),
        .i_ps2_data  (ps2_data_in),
        .o_clk_sync  (w_clk_sync),
        .o_data_sync (w_data_sync),
        .o_clk_fe    (w_clk_fe_raw)
    );

    // While we hold the clock low ourselves any edge we see is our own.
    assign w_clk_drive  = (r_state == ST_INHIBIT) || (r_state == ST_RTS);
    assign w_fe         = w_clk_fe_raw & ~w_clk_drive;
    assign w_timing     = (r_state == ST_SEND) || (r_state == ST_ACK) ||
                          (r_state == ST_WAIT_REL);
    assign w_to_expired = (r_to_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_data_oe = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_next = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_inh_cnt == '0) begin
                    w_next = ST_RTS;
                end
            end
            ST_RTS: begin
                w_data_oe = 1'b1;
                w_next    = ST_SEND;
            end
            ST_SEND: begin
                w_data_oe = r_data_drv;
                if (w_fe) begin
                    if (r_bit_cnt == LAST_BIT_CNT) begin
                        w_next = ST_ACK;
                    end
                end else if (w_to_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_ACK: begin
                if (w_fe) begin
                    w_next = w_data_sync ? ST_ERR : ST_WAIT_REL;
                end else if (w_to_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_WAIT_REL: begin
                if (w_clk_sync && w_data_sync) begin
                    w_next = ST_DONE;
                end else if (w_to_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_err  = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: shift register, bit counter, inhibit timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_data_drv <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        r_shift    <= {2'b11, odd_parity(tx_data), tx_data};
                        r_bit_cnt  <= '0;
                        r_inh_cnt  <= INH_LOAD;
                        r_data_drv <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (r_inh_cnt != '0) begin
                        r_inh_cnt <= r_inh_cnt - INH_W'(1);
                    end
                end
                ST_RTS: begin
                    // Start bit stays on the line until the first device fall.
                    r_data_drv <= 1'b1;
                end
                ST_SEND: begin
                    if (w_fe) begin
                        r_data_drv <= ~r_shift[0];
                        r_shift    <= {1'b1, r_shift[SHIFT_W-1:1]};
                        if (r_bit_cnt != BIT_CNT_MAX) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_data_drv <= 1'b0;
                end
            endcase
        end
    end

    // Device-clock watchdog, restarted on entry to SEND and on every fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_RTS) begin
            r_to_cnt <= TO_LOAD;
        end else if (w_timing) begin
            if (w_fe) begin
                r_to_cnt <= TO_LOAD;
            end else if (!w_to_expired) begin
                r_to_cnt <= r_to_cnt - TO_W'(1);
            end
        end
    end

    assign ps2_clk_oe  = w_clk_drive;
    assign ps2_data_oe = w_data_oe;
    assign tx_busy     = (r_state != ST_IDLE);
    assign tx_done     = w_done;
    assign tx_err      = w_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import kb_pkg::*;

    localparam int INH  = 100;
    localparam int TO   = 500;
    localparam int HALF = 40;   // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line;
    logic       ps2_data_line;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    int errors = 0;
    int checks = 0;
    int done_total = 0;
    int err_total = 0;
    int both_total = 0;

    // Open-collector bus with external pull-ups.
    assign ps2_clk_line  = ps2_clk_oe  ? 1'b0 : dev_clk;
    assign ps2_data_line = ps2_data_oe ? 1'b0 : dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_total++;
        if (tx_err) err_total++;
        if (tx_done && tx_err) both_total++;
    end

    // Pulse tx_start and measure how long the clock line is held low.
    task automatic start_frame(input logic [7:0] d, output int hi,
                               output int first_data, output logic busy_seen);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start   = 1'b0;
        busy_seen  = tx_busy;
        hi         = 0;
        first_data = 0;
        for (int n = 1; n <= INH + 50; n++) begin
            if (!ps2_clk_oe) break;
            hi++;
            if (ps2_data_oe && first_data == 0) first_data = n;
            @(posedge clk);
            #1;
        end
    endtask

    // Device side: nclk clock pulses; bits[0] = start, bits[1..10] sampled
    // on each rising edge. With ack, data is pulled low before the 11th fall.
    task automatic device_frame(input int nclk, input bit ack,
                                output logic [10:0] bits);
        bits = '1;
        repeat (4) @(negedge clk);
        bits[0] = ps2_data_line;
        for (int i = 1; i <= nclk; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i <= 10) bits[i] = ps2_data_line;
            dev_clk = 1'b1;
            if (i == 10 && ack) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000; n++) begin
            if (!tx_busy) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", tx_err); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_set_leds();
        int hi, first, d0, e0;
        logic busy_seen;
        logic [10:0] bits;
        d0 = done_total; e0 = err_total;
        start_frame(CMD_SET_LEDS, hi, first, busy_seen);
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL busy_after_start got=%b exp=1", busy_seen); end
        checks++; if (hi != INH + 1) begin errors++; $display("FAIL inhibit_clk_oe_cycles got=%0d exp=%0d", hi, INH + 1); end
        checks++; if (first != INH + 1) begin errors++; $display("FAIL rts_data_oe_cycle got=%0d exp=%0d", first, INH + 1); end
        device_frame(11, 1'b1, bits);
        wait_idle();
        checks++; if (bits[0] !== 1'b0) begin errors++; $display("FAIL ed_start_bit got=%b exp=0", bits[0]); end
        checks++; if (bits[8:1] !== 8'b1110_1101) begin errors++; $display("FAIL ed_data_bits got=%b exp=11101101", bits[8:1]); end
        checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL ed_parity got=%b exp=1", bits[9]); end
        checks++; if (bits[10] !== 1'b1) begin errors++; $display("FAIL ed_stop got=%b exp=1", bits[10]); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL ed_done_count got=%0d exp=1", done_total - d0); end
        checks++; if (err_total - e0 != 0) begin errors++; $display("FAIL ed_err_count got=%0d exp=0", err_total - e0); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL ed_busy_after got=%b exp=0", tx_busy); end
    endtask

    task automatic test_parity();
        int hi, first, d0;
        logic busy_seen;
        logic [10:0] bits;
        d0 = done_total;
        start_frame(8'h00, hi, first, busy_seen);
        device_frame(11, 1'b1, bits);
        wait_idle();
        checks++; if (bits !== 11'b1_1_00000000_0) begin errors++; $display("FAIL frame_00 got=%b exp=11000000000", bits); end
        start_frame(8'h01, hi, first, busy_seen);
        device_frame(11, 1'b1, bits);
        wait_idle();
        checks++; if (bits !== 11'b1_0_00000001_0) begin errors++; $display("FAIL frame_01 got=%b exp=10000000010", bits); end
        checks++; if (done_total - d0 != 2) begin errors++; $display("FAIL parity_done_count got=%0d exp=2", done_total - d0); end
    endtask

    task automatic test_no_ack();
        int hi, first, d0, e0;
        logic busy_seen;
        logic [10:0] bits;
        d0 = done_total; e0 = err_total;
        start_frame(CMD_RESET, hi, first, busy_seen);
        device_frame(11, 1'b0, bits);
        wait_idle();
        checks++; if (bits !== 11'b1_1_11111111_0) begin errors++; $display("FAIL frame_ff got=%b exp=11111111110", bits); end
        checks++; if (err_total - e0 != 1) begin errors++; $display("FAIL noack_err_count got=%0d exp=1", err_total - e0); end
        checks++; if (done_total - d0 != 0) begin errors++; $display("FAIL noack_done_count got=%0d exp=0", done_total - d0); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL noack_lines got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
    endtask

    task automatic test_timeout();
        int hi, first, d0, e0, n;
        logic busy_seen;
        logic [10:0] bits;
        logic [1:0] lines;
        d0 = done_total; e0 = err_total;
        start_frame(ACK_BYTE, hi, first, busy_seen);
        device_frame(3, 1'b0, bits);
        dev_clk = 1'b0;   // 4th and final fall, then the device goes silent
        n = 0;
        lines = 2'b11;
        for (int k = 0; k < TO + 50; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (tx_err) begin
                lines = {ps2_clk_oe, ps2_data_oe};
                break;
            end
        end
        // 2 sync flops + edge register, then TO cycles of countdown
        checks++; if (n != TO + 3) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TO + 3); end
        checks++; if (lines !== 2'b00) begin errors++; $display("FAIL timeout_lines got=%b exp=00", lines); end
        dev_clk = 1'b1;
        wait_idle();
        repeat (5) @(negedge clk);
        checks++; if (err_total - e0 != 1) begin errors++; $display("FAIL timeout_err_count got=%0d exp=1", err_total - e0); end
        checks++; if (done_total - d0 != 0) begin errors++; $display("FAIL timeout_done_count got=%0d exp=0", done_total - d0); end
    endtask

    task automatic test_reset_mid();
        int hi, first, d0, e0, oe_seen;
        logic busy_seen;
        logic [10:0] bits;
        start_frame(8'h00, hi, first, busy_seen);
        device_frame(5, 1'b0, bits);
        checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL mid_data_driven got=%b exp=1", ps2_data_oe); end
        d0 = done_total; e0 = err_total;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL mid_reset_lines got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", tx_busy); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        oe_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ps2_clk_oe || ps2_data_oe || tx_busy) oe_seen++;
        end
        checks++; if (oe_seen != 0) begin errors++; $display("FAIL mid_idle_after_release got=%0d exp=0", oe_seen); end
        checks++; if ((done_total - d0) + (err_total - e0) != 0) begin errors++; $display("FAIL mid_no_pulse got=%0d exp=0", (done_total - d0) + (err_total - e0)); end
    endtask

    task automatic test_back_to_back();
        int hi, first, d0, act;
        logic busy_seen;
        logic [10:0] bits;
        d0 = done_total;
        start_frame(CMD_ENABLE, hi, first, busy_seen);
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        device_frame(11, 1'b1, bits);
        wait_idle();
        checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL b2b_frame got=%b exp=10111101000", bits); end
        act = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ps2_clk_oe || tx_busy) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL b2b_second_start_dropped got=%0d exp=0", act); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", done_total - d0); end
    endtask

    initial begin
        test_reset();
        test_set_leds();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++; if (both_total != 0) begin errors++; $display("FAIL done_err_overlap got=%0d exp=0", both_total); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
